// File: rtl/eq_pkg.sv
// Shared definitions for the potentiometer scan controller.
// Holds the slot and FSM state encodings, the slot-to-A2D-channel map,
// the A2D command word format and the width of the shared cycle timer.
package eq_pkg;

  // Scan slots, listed in scan order.
  typedef enum logic [2:0] {
    SLOT_LP  = 3'd0,
    SLOT_B1  = 3'd1,
    SLOT_B2  = 3'd2,
    SLOT_B3  = 3'd3,
    SLOT_HP  = 3'd4,
    SLOT_VOL = 3'd5
  } slot_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD1  = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_CMD2  = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_STORE = 3'd5,
    ST_GAP   = 3'd6
  } state_e;

  localparam int NUM_SLOTS = 6;

  // A2D channel per slot, packed 3 bits per slot with LP in the low bits:
  // LP=1, B1=0, B2=4, B3=2, HP=3, VOL=7.
  localparam logic [17:0] SLOT_CHNL_MAP = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

  // A2D command word: {header, channel, padding}.
  localparam logic [1:0]  A2D_CMD_HDR = 2'b00;
  localparam logic [10:0] A2D_CMD_PAD = 11'h000;

  localparam int TMR_W = 16;

  function automatic logic [2:0] slot_chnl(input slot_e s);
    return SLOT_CHNL_MAP[3*s +: 3];
  endfunction

  function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
    return {A2D_CMD_HDR, chnl, A2D_CMD_PAD};
  endfunction

endpackage

// File: rtl/cyc_timer.sv
// Loadable down-counter with an expire flag.
// Ports:
//   i_clk, i_rst : clock and synchronous active-high reset (clears the count)
//   i_load       : load i_val into the counter this cycle
//   i_val        : load value
//   o_expired    : high while the count is zero
// After a load of N the flag rises N cycles later; the counter stops at zero.
module cyc_timer
  import eq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_val,
  output logic             o_expired
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/pot_scan_ctrl.sv
// Potentiometer scan controller: reads six slider pots through an SPI A2D.
// Each slot takes two SPI transactions with the same command; the first
// result is discarded and the low 12 bits of the second are kept.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : scanning enabled while high (checked only between scans)
//   spi_wrt/spi_cmd : transaction start pulse and command word
//   spi_done/spi_rd : transaction complete pulse and returned word
//   lp_gain..volume : latest 12-bit reading per slot
//   scan_done       : one-cycle pulse after a full scan
//   tmo_err         : sticky timeout flag, cleared only by rst
module pot_scan_ctrl
  import eq_pkg::*;
#(
  parameter int GAP_CYCLES = 1024,
  parameter int TMO_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic [11:0] lp_gain,
  output logic [11:0] b1_gain,
  output logic [11:0] b2_gain,
  output logic [11:0] b3_gain,
  output logic [11:0] hp_gain,
  output logic [11:0] volume,
  output logic        scan_done,
  output logic        tmo_err
);

  // GAP is left when the timer reads zero, so it lasts GAP_CYCLES+1 cycles
  // (one cycle for GAP_CYCLES=0). The watchdog is loaded one short so the
  // timeout fires in the TMO_CYCLES-th WAIT cycle and tmo_err is visible
  // TMO_CYCLES cycles after WAIT is entered.
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TMO_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  slot_e            r_slot;
  logic [11:0]      r_gain [NUM_SLOTS];
  logic             r_scan_done;
  logic             r_tmo_err;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_exp;
  logic             w_capture;
  logic             w_timeout;
  logic             w_scan_end;
  logic [3:0]       w_unused_rd;

  assign w_unused_rd = spi_rd[15:12];

  cyc_timer u_timer (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (w_tmr_load),
    .i_val    (w_tmr_val),
    .o_expired(w_tmr_exp)
  );

  always_comb begin
    w_state_nxt = r_state;
    spi_wrt     = 1'b0;
    spi_cmd     = 16'h0000;
    w_tmr_load  = 1'b0;
    w_tmr_val   = TMO_LOAD;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_scan_end  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) w_state_nxt = ST_CMD1;
      end
      ST_CMD1: begin
        spi_wrt     = 1'b1;
        spi_cmd     = a2d_cmd(slot_chnl(r_slot));
        w_tmr_load  = 1'b1;
        w_state_nxt = ST_WAIT1;
      end
      ST_WAIT1: begin
        spi_cmd = a2d_cmd(slot_chnl(r_slot));
        // spi_done is checked first so it wins over a coincident timeout.
        if (spi_done) begin
          w_state_nxt = ST_CMD2;
        end else if (w_tmr_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_STORE;
        end
      end
      ST_CMD2: begin
        spi_wrt     = 1'b1;
        spi_cmd     = a2d_cmd(slot_chnl(r_slot));
        w_tmr_load  = 1'b1;
        w_state_nxt = ST_WAIT2;
      end
      ST_WAIT2: begin
        spi_cmd = a2d_cmd(slot_chnl(r_slot));
        if (spi_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_STORE;
        end else if (w_tmr_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_STORE;
        end
      end
      ST_STORE: begin
        if (r_slot == SLOT_VOL) begin
          w_scan_end  = 1'b1;
          w_tmr_load  = 1'b1;
          w_tmr_val   = GAP_LOAD;
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_CMD1;
        end
      end
      ST_GAP: begin
        if (w_tmr_exp) w_state_nxt = en ? ST_CMD1 : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_slot      <= SLOT_LP;
      r_scan_done <= 1'b0;
      r_tmo_err   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) r_gain[i] <= 12'h000;
    end else begin
      r_state     <= w_state_nxt;
      r_scan_done <= w_scan_end;
      if (w_timeout) r_tmo_err <= 1'b1;
      if (w_capture) r_gain[r_slot] <= spi_rd[11:0];
      // Slot wraps back to LP after VOL so IDLE and GAP both restart at LP.
      if (r_state == ST_STORE)
        r_slot <= (r_slot == SLOT_VOL) ? SLOT_LP : slot_e'(r_slot + 3'd1);
    end
  end

  assign lp_gain   = r_gain[SLOT_LP];
  assign b1_gain   = r_gain[SLOT_B1];
  assign b2_gain   = r_gain[SLOT_B2];
  assign b3_gain   = r_gain[SLOT_B3];
  assign hp_gain   = r_gain[SLOT_HP];
  assign volume    = r_gain[SLOT_VOL];
  assign scan_done = r_scan_done;
  assign tmo_err   = r_tmo_err;

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Directed bench for pot_scan_ctrl with a behavioural A2D responder.
module tb_pot_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd;
  logic [11:0] lp_gain, b1_gain, b2_gain, b3_gain, hp_gain, volume;
  logic        scan_done;
  logic        tmo_err;

  pot_scan_ctrl #(.GAP_CYCLES(10), .TMO_CYCLES(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .spi_wrt  (spi_wrt),
    .spi_cmd  (spi_cmd),
    .spi_done (spi_done),
    .spi_rd   (spi_rd),
    .lp_gain  (lp_gain),
    .b1_gain  (b1_gain),
    .b2_gain  (b2_gain),
    .b3_gain  (b3_gain),
    .hp_gain  (hp_gain),
    .volume   (volume),
    .scan_done(scan_done),
    .tmo_err  (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // A2D model state
  int          cyc = 0;
  int          last_done_cyc = -100;
  int          n_log = 0;
  logic [15:0] cmd_log [32];
  int          data_mode = 0;
  logic        withhold_en = 1'b0;
  logic        withhold_all = 1'b0;
  logic        withheld_flag = 1'b0;
  logic        inject = 1'b0;
  logic        pend = 1'b0;
  logic        pend_real = 1'b0;
  logic [15:0] pend_rd = 16'h0;
  logic        phase = 1'b0;
  logic        resp_real = 1'b0;

  function automatic logic [11:0] chan_val(input logic [2:0] ch);
    case (ch)
      3'd1:    return 12'h111;
      3'd0:    return 12'h222;
      3'd4:    return 12'h333;
      3'd2:    return 12'h444;
      3'd3:    return 12'h555;
      3'd7:    return 12'h666;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [15:0] model_word(input logic [2:0] ch);
    case (data_mode)
      0:       return {4'h0, 12'h5A3};
      1:       return {4'hF, chan_val(ch)};
      default: return {4'hF, chan_val(ch) + 12'h800};
    endcase
  endfunction

  // Responder: answers each spi_wrt with spi_done in the following cycle.
  // Odd transactions of a pair return junk so a wrong capture shows up.
  initial begin
    spi_done = 1'b0;
    spi_rd   = 16'h0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      spi_done = 1'b0;
      if (rst) begin
        pend  = 1'b0;
        phase = 1'b0;
      end else begin
        if (inject) begin
          spi_done  = 1'b1;
          spi_rd    = 16'hFABC;
          resp_real = 1'b1;
          inject    = 1'b0;
        end else if (pend) begin
          spi_done      = 1'b1;
          spi_rd        = pend_rd;
          resp_real     = pend_real;
          last_done_cyc = cyc;
          pend          = 1'b0;
        end
        if (spi_wrt) begin
          if (n_log < 32) cmd_log[n_log] = spi_cmd;
          n_log++;
          if (withhold_all || (withhold_en && phase && spi_cmd == 16'h2000)) begin
            withheld_flag = 1'b1;
          end else begin
            pend      = 1'b1;
            pend_real = phase;
            pend_rd   = phase ? model_word(spi_cmd[13:11]) : 16'hFBAD;
          end
          phase = ~phase;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk); #2;
  endtask

  task automatic wait_scan_done(input string tag);
    int k;
    k = 0;
    while (scan_done !== 1'b1 && k < 1000) begin
      wait_cycle();
      k++;
    end
    chk({tag, "_scan_done_seen"}, 32'(scan_done), 32'h1);
  endtask

  task automatic wait_wrt(input string tag);
    int k;
    k = 0;
    while (spi_wrt !== 1'b1 && k < 1000) begin
      wait_cycle();
      k++;
    end
    chk({tag, "_wrt_seen"}, 32'(spi_wrt), 32'h1);
  endtask

  logic [15:0] exp_cmd [12];
  int          k;
  int          n_before;

  initial begin
    exp_cmd = '{16'h0800, 16'h0800, 16'h0000, 16'h0000, 16'h2000, 16'h2000,
                16'h1000, 16'h1000, 16'h1800, 16'h1800, 16'h3800, 16'h3800};
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) wait_cycle();
    rst = 1'b0;
    wait_cycle();

    // reset state
    chk("rst_wrt", 32'(spi_wrt), 32'h0);
    chk("rst_cmd", 32'(spi_cmd), 32'h0);
    chk("rst_scan_done", 32'(scan_done), 32'h0);
    chk("rst_tmo", 32'(tmo_err), 32'h0);
    chk("rst_lp", 32'(lp_gain), 32'h0);
    chk("rst_b1", 32'(b1_gain), 32'h0);
    chk("rst_b2", 32'(b2_gain), 32'h0);
    chk("rst_b3", 32'(b3_gain), 32'h0);
    chk("rst_hp", 32'(hp_gain), 32'h0);
    chk("rst_vol", 32'(volume), 32'h0);

    // scan 1: constant data, command sequence
    en = 1'b1;
    wait_scan_done("s1");
    chk("s1_lp", 32'(lp_gain), 32'h5A3);
    chk("s1_b1", 32'(b1_gain), 32'h5A3);
    chk("s1_b2", 32'(b2_gain), 32'h5A3);
    chk("s1_b3", 32'(b3_gain), 32'h5A3);
    chk("s1_hp", 32'(hp_gain), 32'h5A3);
    chk("s1_vol", 32'(volume), 32'h5A3);
    chk("s1_ncmd", 32'(n_log), 32'd12);
    for (int i = 0; i < 12; i++) chk($sformatf("s1_cmd%0d", i), 32'(cmd_log[i]), 32'(exp_cmd[i]));
    chk("s1_tmo", 32'(tmo_err), 32'h0);

    // gap length, then scan 2 with per-channel data
    data_mode = 1;
    k = 0;
    do begin
      wait_cycle();
      k++;
    end while (spi_wrt !== 1'b1 && k < 100);
    chk("gap_cycles", 32'(k - 1), 32'd10);

    k = 0;
    while (!(spi_done === 1'b1 && resp_real === 1'b1 && spi_cmd === 16'h0800) && k < 100) begin
      wait_cycle();
      k++;
    end
    chk("lat_lp_before", 32'(lp_gain), 32'h5A3);
    wait_cycle();
    chk("lat_lp_after", 32'(lp_gain), 32'h111);

    wait_scan_done("s2");
    chk("s2_done_latency", 32'(cyc - last_done_cyc), 32'd2);
    chk("s2_lp", 32'(lp_gain), 32'h111);
    chk("s2_b1", 32'(b1_gain), 32'h222);
    chk("s2_b2", 32'(b2_gain), 32'h333);
    chk("s2_b3", 32'(b3_gain), 32'h444);
    chk("s2_hp", 32'(hp_gain), 32'h555);
    chk("s2_vol", 32'(volume), 32'h666);
    wait_cycle();
    chk("s2_done_pulse", 32'(scan_done), 32'h0);

    // scan 3: B2 second transaction never answered
    data_mode   = 2;
    withhold_en = 1'b1;
    k = 0;
    while (withheld_flag !== 1'b1 && k < 200) begin
      wait_cycle();
      k++;
    end
    chk("tmo_withheld", 32'(withheld_flag), 32'h1);
    repeat (20) wait_cycle();
    chk("tmo_not_yet", 32'(tmo_err), 32'h0);
    wait_cycle();
    chk("tmo_rise", 32'(tmo_err), 32'h1);
    wait_scan_done("s3");
    chk("s3_lp", 32'(lp_gain), 32'h911);
    chk("s3_b1", 32'(b1_gain), 32'hA22);
    chk("s3_b2_kept", 32'(b2_gain), 32'h333);
    chk("s3_b3", 32'(b3_gain), 32'hC44);
    chk("s3_hp", 32'(hp_gain), 32'hD55);
    chk("s3_vol", 32'(volume), 32'hE66);

    // scan 4: en dropped during B1
    withhold_en = 1'b0;
    data_mode   = 1;
    k = 0;
    while (!(spi_wrt === 1'b1 && spi_cmd === 16'h0000) && k < 200) begin
      wait_cycle();
      k++;
    end
    chk("b1_wrt_seen", 32'(spi_cmd), 32'h0000);
    en = 1'b0;
    wait_scan_done("s4");
    chk("s4_lp", 32'(lp_gain), 32'h111);
    chk("s4_b2", 32'(b2_gain), 32'h333);
    chk("s4_vol", 32'(volume), 32'h666);
    chk("s4_tmo_sticky", 32'(tmo_err), 32'h1);
    n_before = n_log;
    repeat (40) wait_cycle();
    chk("s4_no_more_wrt", 32'(n_log - n_before), 32'd0);

    // reset in WAIT1 with a stale spi_done three cycles later
    withhold_all = 1'b1;
    en = 1'b1;
    wait_wrt("r1");
    chk("r1_cmd_lp", 32'(spi_cmd), 32'h0800);
    wait_cycle();
    rst = 1'b1;
    en  = 1'b0;
    wait_cycle();
    rst = 1'b0;
    wait_cycle();
    inject = 1'b1;
    repeat (3) wait_cycle();
    chk("r1_lp", 32'(lp_gain), 32'h0);
    chk("r1_b1", 32'(b1_gain), 32'h0);
    chk("r1_b2", 32'(b2_gain), 32'h0);
    chk("r1_vol", 32'(volume), 32'h0);
    chk("r1_tmo", 32'(tmo_err), 32'h0);
    chk("r1_wrt", 32'(spi_wrt), 32'h0);
    chk("r1_cmd", 32'(spi_cmd), 32'h0);
    withhold_all = 1'b0;
    en = 1'b1;
    wait_wrt("r2");
    chk("r2_cmd_lp", 32'(spi_cmd), 32'h0800);
    wait_scan_done("r2");
    chk("r2_lp", 32'(lp_gain), 32'h111);
    chk("r2_vol", 32'(volume), 32'h666);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, observed timeout expected finish");
    $fatal(1);
  end

endmodule
